// File: rtl/freq_meas_ctrl_if.sv
// Result channel of the frequency-meter sequencer: the measured nx/nr pair and its status flags,
// delivered under a valid/ready handshake.
interface freq_meas_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic [CNT_W-1:0] nx_out;
  logic [CNT_W-1:0] nr_out;
  logic             timeout;
  logic             ovf;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output nx_out,
    output nr_out,
    output timeout,
    output ovf,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  nx_out,
    input  nr_out,
    input  timeout,
    input  ovf,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/freq_meas_ctrl.sv
// Equal-precision frequency meter sequencer: edge-aligned gate, nx/nr counters, timeout and
// saturation. Optional macro AUTORANGE_EN shortens the gate by 4x per range step.
module freq_meas_ctrl #(
  parameter int unsigned F_CLK_HZ       = 200_000_000,
  parameter int unsigned GATE_CYCLES    = 200_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 400_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont_en,
  output logic             busy,
  output logic [1:0]       range_o,
  freq_meas_ctrl_if.master res
);

  // F_CLK_HZ is only reported to software; it must still describe a real clock.
  if (F_CLK_HZ == 0 || GATE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_err
    $error("freq_meas_ctrl: F_CLK_HZ, GATE_CYCLES and TIMEOUT_CYCLES must be non-zero");
  end

  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GateLen = CNT_W'(GATE_CYCLES);

  typedef enum logic [2:0] {StIdle, StArm, StGate, StClose, StHold} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [CNT_W-1:0] nx_q, nx_d, nr_q, nr_d, gate_q, gate_d, tmo_q, tmo_d;
  logic [CNT_W-1:0] nx_inc, nr_inc, gate_last;
  logic [CNT_W-1:0] nx_out_q, nx_out_d, nr_out_q, nr_out_d;
  logic             timeout_q, timeout_d, ovf_q, ovf_d;
  logic             arm_entry, meas_active;

`ifdef AUTORANGE_EN
  localparam logic [CNT_W-1:0] NxHi = CNT_W'(1_000_000);
  localparam logic [CNT_W-1:0] NxLo = CNT_W'(1_000);

  logic [1:0] range_q, range_d;

  assign gate_last = (GateLen >> {range_q, 1'b0}) - 1'b1;
  assign range_o   = range_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q <= 2'd0;
    end else begin
      range_q <= range_d;
    end
  end

  // Range only moves on a handshaken, valid result; takes effect at the next ARM.
  always_comb begin
    range_d = range_q;
    if (state_q == StHold && res.result_ready && !timeout_q) begin
      if (nx_out_q > NxHi && range_q != 2'd3) begin
        range_d = range_q + 2'd1;
      end else if (nx_out_q < NxLo && range_q != 2'd0) begin
        range_d = range_q - 2'd1;
      end
    end
  end
`else
  assign gate_last = GateLen - 1'b1;
  assign range_o   = 2'd0;
`endif

  // Open and close edges see the same 3-cycle latency, so it cancels out of nr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  assign nx_inc = (nx_q == '1) ? nx_q : nx_q + 1'b1;
  assign nr_inc = (nr_q == '1) ? nr_q : nr_q + 1'b1;

  assign meas_active = (state_q == StArm) || (state_q == StGate) || (state_q == StClose);

  always_comb begin
    state_d   = state_q;
    nx_d      = nx_q;
    nr_d      = nr_q;
    gate_d    = gate_q;
    tmo_d     = tmo_q;
    nx_out_d  = nx_out_q;
    nr_out_d  = nr_out_q;
    timeout_d = timeout_q;
    ovf_d     = ovf_q;
    arm_entry = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start || cont_en) begin
          arm_entry = 1'b1;
        end
      end
      StArm: begin
        tmo_d = tmo_q + 1'b1;
        if (rise) begin
          state_d = StGate;
        end
      end
      StGate: begin
        tmo_d  = tmo_q + 1'b1;
        gate_d = gate_q + 1'b1;
        nr_d   = nr_inc;
        if (rise) begin
          nx_d = nx_inc;
        end
        if (gate_q == gate_last) begin
          state_d = StClose;
        end
      end
      StClose: begin
        tmo_d = tmo_q + 1'b1;
        nr_d  = nr_inc;
        if (rise) begin
          nx_d     = nx_inc;
          nx_out_d = nx_inc;
          nr_out_d = nr_inc;
          ovf_d    = (nx_inc == '1) || (nr_inc == '1);
          state_d  = StHold;
        end
      end
      StHold: begin
        if (res.result_ready) begin
          if (cont_en) begin
            arm_entry = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A closing edge in the final timeout cycle still yields a valid result.
    if (meas_active && tmo_q == TmoLast && state_d != StHold) begin
      state_d   = StHold;
      timeout_d = 1'b1;
      ovf_d     = 1'b0;
      nx_out_d  = '0;
      nr_out_d  = '0;
    end

    if (arm_entry) begin
      state_d   = StArm;
      nx_d      = '0;
      nr_d      = '0;
      gate_d    = '0;
      tmo_d     = '0;
      timeout_d = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      nx_q      <= '0;
      nr_q      <= '0;
      gate_q    <= '0;
      tmo_q     <= '0;
      nx_out_q  <= '0;
      nr_out_q  <= '0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nx_q      <= nx_d;
      nr_q      <= nr_d;
      gate_q    <= gate_d;
      tmo_q     <= tmo_d;
      nx_out_q  <= nx_out_d;
      nr_out_q  <= nr_out_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy             = (state_q != StIdle);
  assign res.result_valid = (state_q == StHold);
  assign res.nx_out       = nx_out_q;
  assign res.nr_out       = nr_out_q;
  assign res.timeout      = timeout_q;
  assign res.ovf          = ovf_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with GATE_CYCLES=1000, TIMEOUT_CYCLES=5000, CNT_W=32.
module tb_freq_meas_ctrl;

  localparam int unsigned CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in;
  logic       start = 1'b0;
  logic       cont_en = 1'b0;
  logic       busy;
  logic [1:0] range_o;

  int checks = 0;
  int failures = 0;

  int sig_period = 10;
  bit sig_en = 1'b0;
  int sig_cnt = 0;

  freq_meas_ctrl_if #(.CNT_W(CNT_W)) fm_if ();

  freq_meas_ctrl #(
    .F_CLK_HZ      (100_000_000),
    .GATE_CYCLES   (1000),
    .TIMEOUT_CYCLES(5000),
    .CNT_W         (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .start  (start),
    .cont_en(cont_en),
    .busy   (busy),
    .range_o(range_o),
    .res    (fm_if.master)
  );

  always #5 clk = ~clk;

  // Square wave with an exact period of sig_period clocks.
  always @(posedge clk) begin
    if (sig_en) begin
      sig_cnt <= (sig_cnt + 1 >= sig_period) ? 0 : sig_cnt + 1;
      sig_in  <= (sig_cnt < sig_period / 2);
    end else begin
      sig_cnt <= 0;
      sig_in  <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input int max_cycles, output int n, output bit ok);
    n = 0;
    while (!fm_if.result_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    ok = fm_if.result_valid;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fm_if.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fm_if.nx_out !== 32'd0) begin failures++;
      $display("FAIL reset_nx: got %0d, required 0", fm_if.nx_out); end
    checks++; if (fm_if.nr_out !== 32'd0) begin failures++;
      $display("FAIL reset_nr: got %0d, required 0", fm_if.nr_out); end
    checks++; if (fm_if.timeout !== 1'b0) begin failures++;
      $display("FAIL reset_timeout: got %b, required 0", fm_if.timeout); end
    checks++; if (fm_if.ovf !== 1'b0) begin failures++;
      $display("FAIL reset_ovf: got %b, required 0", fm_if.ovf); end
    checks++; if (fm_if.result_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid: got %b, required 0", fm_if.result_valid); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (range_o !== 2'd0) begin failures++;
      $display("FAIL reset_range: got %0d, required 0", range_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    bit ok;
    sig_period = 10;
    sig_en = 1'b1;
    fm_if.result_ready = 1'b1;
    repeat (30) @(negedge clk);
    pulse_start();
    wait_valid(3000, n, ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL single_valid: result_valid=%b after %0d cycles, required 1", ok, n); end
    checks++; if (fm_if.nx_out !== 32'd101) begin failures++;
      $display("FAIL single_nx: got %0d, required 101", fm_if.nx_out); end
    checks++; if (fm_if.nr_out !== 32'd1010) begin failures++;
      $display("FAIL single_nr: got %0d, required 1010", fm_if.nr_out); end
    checks++; if (fm_if.timeout !== 1'b0 || fm_if.ovf !== 1'b0) begin failures++;
      $display("FAIL single_flags: timeout=%b ovf=%b, required 0 0", fm_if.timeout, fm_if.ovf); end
    @(negedge clk);
    checks++; if (fm_if.result_valid !== 1'b0) begin failures++;
      $display("FAIL single_valid_width: valid=%b on 2nd cycle, required 0", fm_if.result_valid); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL single_busy: got %b, required 0", busy); end
  endtask

  task automatic test_cont();
    int n;
    bit ok;
    int unstable;
    logic [CNT_W-1:0] cap_nx, cap_nr;
    sig_period = 7;
    fm_if.result_ready = 1'b0;
    repeat (30) @(negedge clk);
    cont_en = 1'b1;
    wait_valid(3000, n, ok);
    // Gate of 1000 cycles: first 7-cycle edge past it is the 143rd.
    checks++; if (!ok || fm_if.nx_out !== 32'd143 || fm_if.nr_out !== 32'd1001) begin failures++;
      $display("FAIL cont_first: valid=%b nx=%0d nr=%0d, required 1 143 1001",
               ok, fm_if.nx_out, fm_if.nr_out); end
    cap_nx = fm_if.nx_out;
    cap_nr = fm_if.nr_out;
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fm_if.result_valid !== 1'b1 || fm_if.nx_out !== cap_nx || fm_if.nr_out !== cap_nr)
        unstable++;
    end
    checks++; if (unstable != 0) begin failures++;
      $display("FAIL cont_hold_stable: %0d unstable cycles, required 0", unstable); end
    fm_if.result_ready = 1'b1;
    @(negedge clk);
    fm_if.result_ready = 1'b0;
    checks++; if (fm_if.result_valid !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL cont_rearm: valid=%b busy=%b, required 0 1", fm_if.result_valid, busy); end
    repeat (100) @(negedge clk);
    cont_en = 1'b0;
    wait_valid(3000, n, ok);
    checks++; if (!ok || fm_if.nx_out !== 32'd143 || fm_if.nr_out !== 32'd1001) begin failures++;
      $display("FAIL cont_second: valid=%b nx=%0d nr=%0d, required 1 143 1001",
               ok, fm_if.nx_out, fm_if.nr_out); end
    fm_if.result_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fm_if.result_valid !== 1'b0) begin failures++;
      $display("FAIL cont_stop: busy=%b valid=%b, required 0 0", busy, fm_if.result_valid); end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    sig_en = 1'b0;
    fm_if.result_ready = 1'b1;
    repeat (10) @(negedge clk);
    pulse_start();
    wait_valid(6000, n, ok);
    // ARM entered on the edge after start; HOLD follows 5000 cycles later.
    checks++; if (!ok || n != 5000) begin failures++;
      $display("FAIL timeout_latency: valid=%b after %0d cycles, required 1 after 5000", ok, n); end
    checks++; if (fm_if.timeout !== 1'b1) begin failures++;
      $display("FAIL timeout_flag: got %b, required 1", fm_if.timeout); end
    checks++; if (fm_if.nx_out !== 32'd0 || fm_if.nr_out !== 32'd0) begin failures++;
      $display("FAIL timeout_zero: nx=%0d nr=%0d, required 0 0", fm_if.nx_out, fm_if.nr_out); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int n;
    int extra;
    bit ok;
    sig_period = 10;
    sig_en = 1'b1;
    fm_if.result_ready = 1'b1;
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (300) @(negedge clk);
    pulse_start();
    wait_valid(3000, n, ok);
    checks++; if (!ok || fm_if.nx_out !== 32'd101 || fm_if.nr_out !== 32'd1010) begin failures++;
      $display("FAIL ignored_result: valid=%b nx=%0d nr=%0d, required 1 101 1010",
               ok, fm_if.nx_out, fm_if.nr_out); end
    extra = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fm_if.result_valid === 1'b1) extra++;
    end
    checks++; if (extra != 0 || busy !== 1'b0) begin failures++;
      $display("FAIL ignored_count: extra valid cycles=%0d busy=%b, required 0 0", extra, busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    int stale;
    bit ok;
    sig_period = 10;
    sig_en = 1'b1;
    fm_if.result_ready = 1'b1;
    pulse_start();
    repeat (500) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL midreset_busy_before: got %b, required 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || fm_if.result_valid !== 1'b0 || fm_if.nx_out !== 32'd0) begin
      failures++;
      $display("FAIL midreset_clear: busy=%b valid=%b nx=%0d, required 0 0 0",
               busy, fm_if.result_valid, fm_if.nx_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (fm_if.result_valid === 1'b1 || busy === 1'b1) stale++;
    end
    checks++; if (stale != 0) begin failures++;
      $display("FAIL midreset_stale: %0d active cycles, required 0", stale); end
    pulse_start();
    wait_valid(3000, n, ok);
    checks++; if (!ok || fm_if.nx_out !== 32'd101 || fm_if.nr_out !== 32'd1010) begin failures++;
      $display("FAIL midreset_next: valid=%b nx=%0d nr=%0d, required 1 101 1010",
               ok, fm_if.nx_out, fm_if.nr_out); end
    @(negedge clk);
    checks++; if (range_o !== 2'd0) begin failures++;
      $display("FAIL range_fixed: got %0d, required 0", range_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cont();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
Measurement sequencer for the equal-precision frequency meter datapath. It opens a gate window aligned to a sig_in rising edge and closes it on the first sig_in rising edge after the programmed gate time. It counts signal periods (nx) and reference clocks (nr) and delivers the pair under a valid/ready handshake; downstream computes f = nx*F_CLK_HZ/nr. Single clock domain; sig_in is asynchronous and synchronized internally.

Parameters:
F_CLK_HZ, 200_000_000, reference clock frequency (informational only; reported to software, not used in logic)
GATE_CYCLES, 200_000_000, nominal gate length in clk cycles (1 s at 200 MHz)
TIMEOUT_CYCLES, 400_000_000, cycles allowed from ARM entry to the closing edge before the measurement aborts
CNT_W, 32, width of the nx and nr counters and of the gate/timeout timers

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sig_in  in  1  asynchronous signal under test
start  in  1  one-cycle request for a single measurement
cont_en  in  1  level; 1 = re-arm automatically after each handshake
nx_out  out  CNT_W  complete signal periods inside the gate
nr_out  out  CNT_W  clk cycles spanning those periods
timeout  out  1  result is invalid: edges missing within the timeout
ovf  out  1  nx or nr saturated
result_valid  out  1  result registers hold a new measurement
result_ready  in  1  consumer accepts the result
busy  out  1  state is not IDLE
range_o  out  2  current gate range (see Optional Feature)

Behaviour:
- Reset: the asynchronous reset clears all registers. nx_out=0, nr_out=0, timeout=0, ovf=0, result_valid=0, busy=0, range_o=0, state=IDLE. An assertion mid-measurement discards the measurement with no output.
- Sync: two-flop synchronizer followed by a third flop. rise = s2 & ~s3. Edge-detect latency is 3 clk cycles, identical for opening and closing, so it cancels out of nr.
- IDLE: when start=1 or cont_en=1, go to ARM. On entry to ARM, clear nx, nr, the gate timer and the timeout timer.
- ARM: wait for rise, then go to GATE. The opening-edge cycle is not counted in nr or nx.
- GATE: nr increments every cycle and nx increments on every rise. The gate timer counts 0..GATE_CYCLES-1. When the timer equals GATE_CYCLES-1, go to CLOSE; a rise in that same cycle is still counted.
- CLOSE: nr increments every cycle. On rise, nx increments, then copy nx/nr to nx_out/nr_out and go to HOLD. For a periodic input of period P clocks, nr = nx*P exactly.
- Timeout: the timeout timer runs through ARM, GATE and CLOSE. When it reaches TIMEOUT_CYCLES-1, go to HOLD with timeout=1, nx_out=0 and nr_out=0.
- Saturation: nx and nr stick at all-ones. Any saturation sets ovf for that result.
- HOLD: result_valid=1, and the outputs are stable until result_ready=1 is sampled. In that cycle result_valid drops on the next edge. The block then goes to ARM if cont_en=1, else to IDLE. result_ready while result_valid=0 is ignored.
- start while busy=1 is ignored (no queuing). Dropping cont_en mid-measurement completes the current measurement, then returns to IDLE.
- timeout and ovf are registered with the result and cleared on the next entry to ARM.

Optional Feature:
AUTORANGE_EN
- Defined: the effective gate length is GATE_CYCLES >> (2*range), with range held in a 2-bit register (0..3).
- After each handshaken non-timeout result:
  - if nx_out > 1_000_000 and range < 3, range increments;
  - if nx_out < 1_000 and range > 0, range decrements.
- The new range applies from the next ARM. range_o shows the register.
- Undefined: range is constant 0, range_o=0, and the gate length is always GATE_CYCLES.

Test Plan:
All scenarios use GATE_CYCLES=1000, TIMEOUT_CYCLES=5000, CNT_W=32.
- Period-10 square wave, start pulse, result_ready held 1 -> nx_out=101, nr_out=1010, timeout=0, ovf=0; result_valid high for exactly 1 cycle; busy returns to 0.
- Period-7 square wave, cont_en=1, result_ready held 0 for 50 cycles after valid -> outputs are stable while valid; a second measurement starts only after the handshake; both results satisfy nr_out = 7*nx_out.
- sig_in stuck at 0, start -> HOLD at 5000 cycles after ARM entry; timeout=1, nx_out=0, nr_out=0.
- start pulsed during GATE -> ignored; exactly one result is produced.
- rst_n asserted during GATE, released, then start -> no stale result; the next result is correct (nx_out=101, nr_out=1010 for period 10).
- AUTORANGE_EN defined, GATE_CYCLES=200_000_000, period-2 signal -> nx_out > 1_000_000, so range_o steps to 1. With nx_out still > 1_000_000 on the next result, range_o steps to 2. nr_out = 2*nx_out at every step.
